// File: rtl/posit_prod_norm_stage.sv
// posit_prod_norm_stage: normalizes the 14-bit mantissa product to hidden-bit
// form (6 fraction bits + guard + sticky), adjusts/saturates the scale and
// hands the result downstream through a 2-entry skid buffer.
module posit_prod_norm_stage #(
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [13:0]   in_prod,
  input  logic [SW-1:0] in_scale,
  input  logic          in_sign,
  input  logic          in_zero,
  input  logic          in_nar,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [5:0]    out_frac,
  output logic          out_guard,
  output logic          out_sticky,
  output logic [SW-1:0] out_scale,
  output logic          out_sign,
  output logic          out_zero,
  output logic          out_nar,
  output logic          out_ovf,
  output logic          out_err
);

  typedef struct packed {
    logic [5:0]    frac;
    logic          guard;
    logic          sticky;
    logic [SW-1:0] scale;
    logic          sign;
    logic          zero;
    logic          nar;
    logic          ovf;
    logic          err;
  } res_t;

  localparam logic [SW-1:0] SCALE_MAX = {1'b0, {(SW-1){1'b1}}};

  res_t        norm, main_q, skid_q, main_d, skid_d;
  logic        main_valid, skid_valid, main_vd, skid_vd;
  logic        accept;
  logic        inc;
  logic [SW:0] sum;

  assign accept = in_valid && in_ready;

  // Normalize the raw product; a set top bit means the product is in [2,4)
  // and the scale must be bumped by one, which is the only overflow source.
  always_comb begin
    norm      = '0;
    norm.sign = in_sign;
    norm.zero = in_zero;
    norm.nar  = in_nar;
    inc       = in_prod[13];
    sum       = {in_scale[SW-1], in_scale} + {{SW{1'b0}}, inc};
    if (!(in_nar || in_zero)) begin
      if (in_prod[13]) begin
        norm.frac   = in_prod[12:7];
        norm.guard  = in_prod[6];
        norm.sticky = |in_prod[5:0];
      end else begin
        // Malformed (bits 13:12 both clear) products share this path but flag err.
        norm.frac   = in_prod[11:6];
        norm.guard  = in_prod[5];
        norm.sticky = |in_prod[4:0];
        norm.err    = ~in_prod[12];
      end
      // Positive overflow: sign-extended sum went from 0 to 1 in the top data bit.
      norm.ovf   = ~sum[SW] & sum[SW-1];
      norm.scale = norm.ovf ? SCALE_MAX : sum[SW-1:0];
    end
  end

  // Skid-buffer next state: refill main from skid first to keep ordering.
  always_comb begin
    main_d  = main_q;
    skid_d  = skid_q;
    main_vd = main_valid;
    skid_vd = skid_valid;
    if (!main_valid || out_ready) begin
      if (skid_valid) begin
        main_d  = skid_q;
        main_vd = 1'b1;
        if (accept) skid_d = norm;
        else        skid_vd = 1'b0;
      end else if (accept) begin
        main_d  = norm;
        main_vd = 1'b1;
      end else begin
        main_vd = 1'b0;
      end
    end else if (accept) begin
      skid_d  = norm;
      skid_vd = 1'b1;
    end
  end

  // State registers; reset drops both entries at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_valid <= main_vd;
      skid_valid <= skid_vd;
      in_ready   <= ~skid_vd;
    end
  end

  assign out_valid  = main_valid;
  assign out_frac   = main_q.frac;
  assign out_guard  = main_q.guard;
  assign out_sticky = main_q.sticky;
  assign out_scale  = main_q.scale;
  assign out_sign   = main_q.sign;
  assign out_zero   = main_q.zero;
  assign out_nar    = main_q.nar;
  assign out_ovf    = main_q.ovf;
  assign out_err    = main_q.err;

endmodule

// File: tb/tb_posit_prod_norm_stage.sv
// Bench for posit_prod_norm_stage: directed table, backpressure and reset
// sequences, then randomized traffic checked by an arithmetic reference model.
module tb_posit_prod_norm_stage;
  localparam int SW   = 8;
  localparam int BW   = SW + 13;
  localparam int MAXS = (1 << (SW-1)) - 1;

  logic          clk = 0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [13:0]   in_prod;
  logic [SW-1:0] in_scale;
  logic          in_sign, in_zero, in_nar;
  logic          out_valid, out_ready;
  logic [5:0]    out_frac;
  logic          out_guard, out_sticky;
  logic [SW-1:0] out_scale;
  logic          out_sign, out_zero, out_nar, out_ovf, out_err;

  posit_prod_norm_stage #(.SW(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_scale(in_scale), .in_sign(in_sign),
    .in_zero(in_zero), .in_nar(in_nar), .out_valid(out_valid),
    .out_ready(out_ready), .out_frac(out_frac), .out_guard(out_guard),
    .out_sticky(out_sticky), .out_scale(out_scale), .out_sign(out_sign),
    .out_zero(out_zero), .out_nar(out_nar), .out_ovf(out_ovf), .out_err(out_err)
  );

  always #5 clk = ~clk;

  wire [BW-1:0] dout = {out_frac, out_guard, out_sticky, out_scale,
                        out_sign, out_zero, out_nar, out_ovf, out_err};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] pack(input int f, g, st, sc, input bit sg, z, n,
                                         input int ov, er);
    logic [SW-1:0] sv;
    sv = sc[SW-1:0];
    return {f[5:0], g[0], st[0], sv, sg, z, n, ov[0], er[0]};
  endfunction

  // Reference: value-level view of the product (scaled by 2^12) with plain arithmetic.
  function automatic logic [BW-1:0] model(input int p, input int sc, input bit sg, z, n);
    int f, g, st, s, ov, er, sh;
    f = 0; g = 0; st = 0; s = 0; ov = 0; er = 0;
    if (!(z || n)) begin
      sh = (p >= 8192) ? 7 : 6;
      f  = (p >> sh) % 64;
      g  = (p >> (sh-1)) % 2;
      st = ((p % (1 << (sh-1))) != 0) ? 1 : 0;
      s  = sc + ((p >= 8192) ? 1 : 0);
      if (s > MAXS) begin s = MAXS; ov = 1; end
      er = (p < 4096) ? 1 : 0;
    end
    return pack(f, g, st, s, sg, z, n, ov, er);
  endfunction

  // Scoreboard of accepted items, in order.
  logic [BW-1:0] q[$];
  logic [BW-1:0] held;
  bit            stall = 0;

  // Monitor on the falling edge: predicts the next rising edge's transfers.
  always @(negedge clk) begin
    if (rst) begin
      stall = 0;
    end else begin
      chk("in_ready", in_ready, q.size() < 2);
      chk("out_valid", out_valid, q.size() != 0);
      if (stall) chk("stable", dout, held);
      if (out_valid && out_ready && q.size() != 0) chk("order", dout, q.pop_front());
      stall = out_valid && !out_ready;
      held  = dout;
      if (in_valid && in_ready)
        q.push_back(model(int'(in_prod), int'($signed(in_scale)), in_sign, in_zero, in_nar));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input int p, input int sc, input bit sg, z, n);
    in_prod = p[13:0]; in_scale = sc[SW-1:0];
    in_sign = sg; in_zero = z; in_nar = n; in_valid = 1;
  endtask

  // Present one item and hold it until accepted (bounded).
  task automatic send(input int p, input int sc, input bit sg, z, n);
    int t;
    t = 0;
    drive(p, sc, sg, z, n);
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 50) begin chk("send_timeout", t, 0); break; end
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  typedef struct {
    string nm;
    int p, sc; bit sg, z, n;
    int f, g, st, esc, ov, er;
  } vec_t;

  vec_t vt[9];
  bit   rdone;

  initial begin
    vt[0] = '{"bit13",      'h3F80,    5, 0, 0, 0, 'h3F, 0, 0,    6, 0, 0};
    vt[1] = '{"bit12",      'h1041,   -3, 1, 0, 0, 'h01, 0, 1,   -3, 0, 0};
    vt[2] = '{"ovf",        'h2000,  127, 0, 0, 0, 'h00, 0, 0,  127, 1, 0};
    vt[3] = '{"malformed",  'h0800,   10, 0, 0, 0, 'h20, 0, 0,   10, 0, 1};
    vt[4] = '{"nar_zero",   'h3FFF,   20, 0, 1, 1, 0,    0, 0,    0, 0, 0};
    vt[5] = '{"zero_only",  'h1234,   -5, 1, 1, 0, 0,    0, 0,    0, 0, 0};
    vt[6] = '{"min_scale",  'h3FFF, -128, 1, 0, 0, 'h3F, 1, 1, -127, 0, 0};
    vt[7] = '{"max_no_inc", 'h1FFF,  127, 0, 0, 0, 'h3F, 1, 1,  127, 0, 0};
    vt[8] = '{"to_max",     'h2041,  126, 0, 0, 0, 'h00, 1, 1,  127, 0, 0};

    rst = 1; in_valid = 0; in_prod = 0; in_scale = 0;
    in_sign = 0; in_zero = 0; in_nar = 0; out_ready = 1;
    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_data", dout, 0);
    #1 rst = 0;
    step();
    chk("idle_out_valid", out_valid, 0);

    // Directed vectors, one cycle latency each.
    foreach (vt[i]) begin
      send(vt[i].p, vt[i].sc, vt[i].sg, vt[i].z, vt[i].n);
      chk({"lat_", vt[i].nm}, out_valid, 1);
      chk(vt[i].nm, dout, pack(vt[i].f, vt[i].g, vt[i].st, vt[i].esc,
                               vt[i].sg, vt[i].z, vt[i].n, vt[i].ov, vt[i].er));
    end
    step();

    // Backpressure: A to main, B to skid, C held by the source.
    out_ready = 0;
    drive('h3000, 1, 0, 0, 0); step();
    chk("bp_a_main", dout, model('h3000, 1, 0, 0, 0));
    chk("bp_a_ready", in_ready, 1);
    drive('h1800, 2, 0, 0, 0); step();
    chk("bp_b_ready", in_ready, 0);
    chk("bp_hold_a", dout, model('h3000, 1, 0, 0, 0));
    drive('h2C00, 3, 1, 0, 0); step();
    chk("bp_c_held", in_ready, 0);
    out_ready = 1; step();
    chk("bp_out_b", dout, model('h1800, 2, 0, 0, 0));
    chk("bp_ready_back", in_ready, 1);
    step();
    in_valid = 0;
    chk("bp_out_c", dout, model('h2C00, 3, 1, 0, 0));
    step();
    chk("bp_empty", out_valid, 0);

    // Reset with both entries full.
    out_ready = 0;
    send('h3F00, 7, 0, 0, 0);
    send('h1F00, 8, 0, 0, 0);
    chk("mr_full", in_ready, 0);
    #1 rst = 1;
    #1;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_in_ready", in_ready, 1);
    q.delete();
    @(posedge clk); #2 rst = 0;
    out_ready = 1;
    repeat (3) step();
    chk("mr_no_stale", out_valid, 0);

    // Randomized traffic with random backpressure.
    rdone = 0;
    fork
      begin
        while (!rdone) begin
          @(posedge clk); #1;
          out_ready = ($urandom % 4) != 0;
        end
      end
      begin
        for (int k = 0; k < 400; k++) begin
          int p;
          bit z, n;
          p = ($urandom % 8 == 0) ? $urandom_range(0, 16383) : $urandom_range(4096, 16383);
          z = ($urandom % 8) == 0;
          n = ($urandom % 8) == 0;
          send(p, int'($signed(SW'($urandom))), $urandom % 2, z, n);
          if ($urandom % 5 == 0) step();
        end
        rdone = 1;
      end
    join

    out_ready = 1;
    for (int t = 0; t < 100 && q.size() != 0; t++) step();
    chk("drain", q.size(), 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
